// File: rtl/raycast_node_server_pkg.sv
// Shared definitions for the raycast node server: default widths and the
// responder FSM state encoding, so benches and neighbours agree on them.
package raycast_node_server_pkg;

  localparam int DEF_ADR_W   = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FETCH  = 3'd2,
    ST_ACK    = 3'd3,
    ST_FLUSH  = 3'd4
  } node_state_e;

endpackage

// File: rtl/raycast_node_cache_mem.sv
// Direct-mapped node cache storage: one node word per line, a tag per line
// and a valid vector that can be wiped in a single cycle. The read port is
// registered so the lookup result appears one cycle after the request.
module raycast_node_cache_mem #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic               clear_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic              rd_valid_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [DATA_W-1:0] rd_data_q;

  // Valid bits: reset and a scene flush wipe every line; a fill marks its line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid vector decides what is live.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Registered read port: captures the addressed line so the FSM compares it next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
    end else if (rd_en_i) begin
      rd_valid_q <= valid_q[rd_idx_i];
      rd_tag_q   <= tag_q[rd_idx_i];
      rd_data_q  <= data_q[rd_idx_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/raycast_node_server.sv
// Node-fetch responder for raycast_core: serves node words from a small
// direct-mapped cache and fetches misses through a single-outstanding
// Wishbone-style read master. Far-child misses bypass allocation so they do
// not evict near nodes, and scene flushes wait for the current request.
module raycast_node_server
  import raycast_node_server_pkg::*;
#(
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              node_req_i,
  input  logic              node_req_far_i,
  input  logic [ADR_W-1:0]  node_req_adr_i,
  output logic              node_ack_o,
  output logic [DATA_W-1:0] node_data_o,
  output logic [ADR_W-1:0]  node_adr_o,
  input  logic              flush_i,
  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic [ADR_W-1:0]  mem_adr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_dat_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);

  localparam int TAG_W = ADR_W - INDEX_W;

  node_state_e       state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic              far_q, far_d;
  logic              flush_pend_q, flush_pend_d;
  logic              node_ack_q, node_ack_d;
  logic [DATA_W-1:0] node_data_q, node_data_d;
  logic [ADR_W-1:0]  node_adr_q, node_adr_d;
  logic              mem_cyc_q, mem_cyc_d;
  logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic              rd_en;
  logic              wr_en;
  logic              clear;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              cache_hit;

  raycast_node_cache_mem #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_cache (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en),
    .rd_idx_i   (node_req_adr_i[INDEX_W-1:0]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (adr_q[INDEX_W-1:0]),
    .wr_tag_i   (adr_q[ADR_W-1:INDEX_W]),
    .wr_data_i  (mem_dat_i),
    .clear_i    (clear)
  );

  assign cache_hit = rd_valid && (rd_tag == adr_q[ADR_W-1:INDEX_W]);

  // State and output registers; reset abandons any memory cycle and drops all results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      far_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      node_ack_q   <= 1'b0;
      node_data_q  <= '0;
      node_adr_q   <= '0;
      mem_cyc_q    <= 1'b0;
      mem_adr_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      far_q        <= far_d;
      flush_pend_q <= flush_pend_d;
      node_ack_q   <= node_ack_d;
      node_data_q  <= node_data_d;
      node_adr_q   <= node_adr_d;
      mem_cyc_q    <= mem_cyc_d;
      mem_adr_q    <= mem_adr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Next-state logic: flushes outside IDLE are remembered and run once the request completes.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    far_d        = far_q;
    flush_pend_d = flush_pend_q | flush_i;
    node_ack_d   = 1'b0;
    node_data_d  = node_data_q;
    node_adr_d   = node_adr_q;
    mem_cyc_d    = mem_cyc_q;
    mem_adr_d    = mem_adr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_pend_q || flush_i) begin
          state_d = ST_FLUSH;
        end else if (node_req_i) begin
          adr_d   = node_req_adr_i;
          far_d   = node_req_far_i;
          rd_en   = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cache_hit) begin
          node_ack_d  = 1'b1;
          node_data_d = rd_data;
          node_adr_d  = adr_q;
          hit_cnt_d   = hit_cnt_q + 32'd1;
          state_d     = ST_ACK;
        end else begin
          mem_cyc_d  = 1'b1;
          mem_adr_d  = adr_q;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          mem_cyc_d   = 1'b0;
          node_ack_d  = 1'b1;
          node_data_d = mem_dat_i;
          node_adr_d  = adr_q;
          wr_en       = !far_q;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        clear        = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign node_ack_o   = node_ack_q;
  assign node_data_o  = node_data_q;
  assign node_adr_o   = node_adr_q;
  assign mem_cyc_o    = mem_cyc_q;
  assign mem_stb_o    = mem_cyc_q;
  assign mem_adr_o    = mem_adr_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_raycast_node_server.sv
// Directed bench for raycast_node_server: a core-side driver plus an inline
// memory responder, with hand-computed expectations in each scenario task.
module tb_raycast_node_server;

  logic        clk;
  logic        rst;
  logic        nodeReq;
  logic        nodeReqFar;
  logic [31:0] nodeReqAdr;
  logic        nodeAck;
  logic [31:0] nodeData;
  logic [31:0] nodeAdr;
  logic        flush;
  logic        memCyc;
  logic        memStb;
  logic [31:0] memAdr;
  logic        memAck;
  logic [31:0] memDat;
  logic [31:0] hitCount;
  logic [31:0] missCount;

  int errors;
  int checks;

  logic        rAck;
  logic [31:0] rData;
  logic [31:0] rAdr;
  int          rLatency;
  logic        rSawMem;
  logic [31:0] rMemAdr;
  int          rCycCycles;
  logic        rStbBad;
  int          rIdleAcks;
  int          rIdleCyc;

  raycast_node_server dut (
    .clk            (clk),
    .rst            (rst),
    .node_req_i     (nodeReq),
    .node_req_far_i (nodeReqFar),
    .node_req_adr_i (nodeReqAdr),
    .node_ack_o     (nodeAck),
    .node_data_o    (nodeData),
    .node_adr_o     (nodeAdr),
    .flush_i        (flush),
    .mem_cyc_o      (memCyc),
    .mem_stb_o      (memStb),
    .mem_adr_o      (memAdr),
    .mem_ack_i      (memAck),
    .mem_dat_i      (memDat),
    .hit_count_o    (hitCount),
    .miss_count_o   (missCount)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one core request and plays the memory, acking memDelay cycles into the bus cycle.
  task automatic doRequest(input logic [31:0] adr, input logic far, input int memDelay,
                           input logic [31:0] memData, input logic flushInFetch);
    int  cycCnt;
    bit  done;
    cycCnt     = 0;
    done       = 0;
    rAck       = 1'b0;
    rData      = '0;
    rAdr       = '0;
    rLatency   = 0;
    rSawMem    = 1'b0;
    rMemAdr    = '0;
    rCycCycles = 0;
    rStbBad    = 1'b0;
    @(negedge clk);
    nodeReq    = 1'b1;
    nodeReqAdr = adr;
    nodeReqFar = far;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (memCyc) begin
        cycCnt++;
        rCycCycles++;
        rSawMem = 1'b1;
        rMemAdr = memAdr;
      end
      if (memStb !== memCyc) rStbBad = 1'b1;
      memAck = memCyc && (cycCnt == memDelay);
      memDat = memData;
      if (flushInFetch && memCyc && cycCnt == 1) flush = 1'b1;
      if (nodeAck) begin
        rAck     = 1'b1;
        rData    = nodeData;
        rAdr     = nodeAdr;
        rLatency = i;
        nodeReq  = 1'b0;
        done     = 1;
      end
    end
    nodeReq = 1'b0;
    memAck  = 1'b0;
    flush   = 1'b0;
  endtask

  // Lets the DUT run with no requests and counts any stray acks or bus cycles.
  task automatic idleCycles(input int n);
    rIdleAcks = 0;
    rIdleCyc  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (nodeAck) rIdleAcks++;
      if (memCyc) rIdleCyc++;
    end
  endtask

  // Reset values while reset is held.
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (nodeAck !== 1'b0 || memCyc !== 1'b0 || memStb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: ack=%b cyc=%b stb=%b required 0 0 0", nodeAck, memCyc, memStb);
    end
    checks++;
    if (nodeData !== 32'h0 || nodeAdr !== 32'h0 || memAdr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_buses: data=%h adr=%h memAdr=%h required zeros", nodeData, nodeAdr, memAdr);
    end
    checks++;
    if (hitCount !== 32'd0 || missCount !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: hit=%0d miss=%0d required 0 0", hitCount, missCount);
    end
    rst = 1'b0;
  endtask

  // Cold miss at 0x100 with a three-cycle memory response.
  task automatic test_cold_miss();
    doRequest(32'h100, 1'b0, 3, 32'hDEADBEEF, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'hDEADBEEF || rAdr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL cold_ack: ack=%b data=%h adr=%h required 1 deadbeef 00000100", rAck, rData, rAdr);
    end
    checks++;
    if (rSawMem !== 1'b1 || rMemAdr !== 32'h100 || rCycCycles != 3) begin
      errors++;
      $display("[TB] FAIL cold_mem: saw=%b adr=%h cyc_cycles=%0d required 1 00000100 3", rSawMem, rMemAdr, rCycCycles);
    end
    checks++;
    if (rStbBad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cold_stb: stb differed from cyc=%b required 0", rStbBad);
    end
    checks++;
    if (rLatency != 5) begin
      errors++;
      $display("[TB] FAIL cold_latency: got %0d required 5", rLatency);
    end
    checks++;
    if (missCount !== 32'd1 || hitCount !== 32'd0) begin
      errors++;
      $display("[TB] FAIL cold_counts: hit=%0d miss=%0d required 0 1", hitCount, missCount);
    end
    idleCycles(3);
    checks++;
    if (rIdleAcks != 0 || rIdleCyc != 0) begin
      errors++;
      $display("[TB] FAIL cold_quiet: acks=%0d cyc=%0d required 0 0", rIdleAcks, rIdleCyc);
    end
  endtask

  // Repeat of 0x100 is served from the cache in two cycles.
  task automatic test_hit();
    doRequest(32'h100, 1'b0, 1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'hDEADBEEF || rAdr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL hit_ack: ack=%b data=%h adr=%h required 1 deadbeef 00000100", rAck, rData, rAdr);
    end
    checks++;
    if (rSawMem !== 1'b0 || rLatency != 2) begin
      errors++;
      $display("[TB] FAIL hit_timing: mem=%b latency=%0d required 0 2", rSawMem, rLatency);
    end
    checks++;
    if (hitCount !== 32'd1 || missCount !== 32'd1) begin
      errors++;
      $display("[TB] FAIL hit_counts: hit=%0d miss=%0d required 1 1", hitCount, missCount);
    end
  endtask

  // 0x140 shares index 0 with 0x100: far misses must not evict, near misses must.
  task automatic test_conflict_far();
    doRequest(32'h140, 1'b1, 1, 32'h11, 1'b0);
    checks++;
    if (rSawMem !== 1'b1 || rData !== 32'h11 || rAdr !== 32'h140) begin
      errors++;
      $display("[TB] FAIL far_miss: mem=%b data=%h adr=%h required 1 00000011 00000140", rSawMem, rData, rAdr);
    end
    doRequest(32'h100, 1'b0, 1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (rSawMem !== 1'b0 || rData !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL far_no_evict: mem=%b data=%h required 0 deadbeef", rSawMem, rData);
    end
    doRequest(32'h140, 1'b0, 2, 32'h22, 1'b0);
    checks++;
    if (rSawMem !== 1'b1 || rData !== 32'h22) begin
      errors++;
      $display("[TB] FAIL near_fill: mem=%b data=%h required 1 00000022", rSawMem, rData);
    end
    doRequest(32'h140, 1'b0, 1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (rSawMem !== 1'b0 || rData !== 32'h22) begin
      errors++;
      $display("[TB] FAIL near_hit: mem=%b data=%h required 0 00000022", rSawMem, rData);
    end
    doRequest(32'h100, 1'b0, 1, 32'hDEADBEEF, 1'b0);
    checks++;
    if (rSawMem !== 1'b1 || rData !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL evicted_miss: mem=%b data=%h required 1 deadbeef", rSawMem, rData);
    end
    checks++;
    if (hitCount !== 32'd3 || missCount !== 32'd4) begin
      errors++;
      $display("[TB] FAIL conflict_counts: hit=%0d miss=%0d required 3 4", hitCount, missCount);
    end
  endtask

  // Flush pulse mid-fetch: the request finishes, then the cache is wiped.
  task automatic test_flush_deferral();
    doRequest(32'h200, 1'b0, 3, 32'h0BADF00D, 1'b1);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'h0BADF00D || rAdr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL flush_ack: ack=%b data=%h adr=%h required 1 0badf00d 00000200", rAck, rData, rAdr);
    end
    doRequest(32'h200, 1'b0, 1, 32'h0BADF00D, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rSawMem !== 1'b1 || rData !== 32'h0BADF00D) begin
      errors++;
      $display("[TB] FAIL flush_invalidated: ack=%b mem=%b data=%h required 1 1 0badf00d", rAck, rSawMem, rData);
    end
    checks++;
    if (hitCount !== 32'd3 || missCount !== 32'd6) begin
      errors++;
      $display("[TB] FAIL flush_counts: hit=%0d miss=%0d required 3 6", hitCount, missCount);
    end
  endtask

  // Reset during a memory cycle drops the bus, the ack and the counters; late acks are ignored.
  task automatic test_reset_mid_fetch();
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    nodeReq    = 1'b1;
    nodeReqAdr = 32'h100;
    nodeReqFar = 1'b0;
    while (!memCyc && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (memCyc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_fetch_started: cyc=%b required 1", memCyc);
    end
    rst     = 1'b1;
    nodeReq = 1'b0;
    @(negedge clk);
    checks++;
    if (memCyc !== 1'b0 || memStb !== 1'b0 || nodeAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_abandon: cyc=%b stb=%b ack=%b required 0 0 0", memCyc, memStb, nodeAck);
    end
    checks++;
    if (hitCount !== 32'd0 || missCount !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_counts: hit=%0d miss=%0d required 0 0", hitCount, missCount);
    end
    rst    = 1'b0;
    memAck = 1'b1;
    memDat = 32'h55;
    @(negedge clk);
    memAck = 1'b0;
    idleCycles(4);
    checks++;
    if (nodeAck !== 1'b0 || rIdleAcks != 0 || rIdleCyc != 0) begin
      errors++;
      $display("[TB] FAIL rst_late_ack: ack=%b acks=%0d cyc=%0d required 0 0 0", nodeAck, rIdleAcks, rIdleCyc);
    end
    doRequest(32'h100, 1'b0, 2, 32'h77, 1'b0);
    checks++;
    if (rSawMem !== 1'b1 || rData !== 32'h77 || missCount !== 32'd1 || hitCount !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_then_miss: mem=%b data=%h miss=%0d hit=%0d required 1 00000077 1 0", rSawMem, rData, missCount, hitCount);
    end
  endtask

  // Requests issued the cycle after each ack: no lost or repeated responses.
  task automatic test_back_to_back();
    doRequest(32'h100, 1'b0, 1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'h77 || rAdr !== 32'h100 || rLatency != 2) begin
      errors++;
      $display("[TB] FAIL b2b_first: ack=%b data=%h adr=%h lat=%0d required 1 00000077 00000100 2", rAck, rData, rAdr, rLatency);
    end
    doRequest(32'h101, 1'b0, 2, 32'hA1, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'hA1 || rAdr !== 32'h101 || rLatency != 4) begin
      errors++;
      $display("[TB] FAIL b2b_second: ack=%b data=%h adr=%h lat=%0d required 1 000000a1 00000101 4", rAck, rData, rAdr, rLatency);
    end
    doRequest(32'h101, 1'b0, 1, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (rAck !== 1'b1 || rData !== 32'hA1 || rSawMem !== 1'b0 || rLatency != 2) begin
      errors++;
      $display("[TB] FAIL b2b_third: ack=%b data=%h mem=%b lat=%0d required 1 000000a1 0 2", rAck, rData, rSawMem, rLatency);
    end
    idleCycles(4);
    checks++;
    if (rIdleAcks != 0) begin
      errors++;
      $display("[TB] FAIL b2b_no_dup: extra acks=%0d required 0", rIdleAcks);
    end
    checks++;
    if (hitCount !== 32'd2 || missCount !== 32'd2) begin
      errors++;
      $display("[TB] FAIL b2b_counts: hit=%0d miss=%0d required 2 2", hitCount, missCount);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    nodeReq    = 1'b0;
    nodeReqFar = 1'b0;
    nodeReqAdr = '0;
    flush      = 1'b0;
    memAck     = 1'b0;
    memDat     = '0;
    $display("[TB] starting raycast_node_server bench");
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict_far();
    test_flush_deferral();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raycast_node_server.md
Name: raycast_node_server

Overview:
Responder side of the raycast_core node-fetch interface. Accepts node_req/node_req_far/node_req_adr from one core and returns node_ack with node_data and the echoed node_adr. Serves hits from a small direct-mapped node cache. Misses go to external memory through a single-outstanding Wishbone-style read master. Sits between raycast_core and the memory arbiter.

Parameters:
ADR_W, 32, width of word address on node and memory sides
DATA_W, 32, node word width
INDEX_W, 6, cache index bits (2**INDEX_W lines, one node word per line)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
node_req_i  in  1  core request; held high with stable address until node_ack_o seen
node_req_far_i  in  1  far-child hint, qualified by node_req_i
node_req_adr_i  in  ADR_W  requested node word address
node_ack_o  out  1  one-cycle response strobe
node_data_o  out  DATA_W  node word, valid only while node_ack_o=1
node_adr_o  out  ADR_W  address of returned word, valid only while node_ack_o=1
flush_i  in  1  one-cycle pulse: invalidate entire cache (new scene loaded)
mem_cyc_o  out  1  memory cycle active
mem_stb_o  out  1  memory strobe, equal to mem_cyc_o
mem_adr_o  out  ADR_W  memory read address
mem_ack_i  in  1  memory read data valid
mem_dat_i  in  DATA_W  memory read data
hit_count_o  out  32  number of hits since reset, wraps
miss_count_o  out  32  number of misses since reset, wraps

Behaviour:
- Reset: state IDLE; node_ack_o=0; node_data_o=0; node_adr_o=0; mem_cyc_o=mem_stb_o=0; mem_adr_o=0; all valid bits=0; both counters=0; pending-flush=0.
- Address split: index = adr[INDEX_W-1:0]; tag = adr[ADR_W-1:INDEX_W].
- FSM states: IDLE, LOOKUP, FETCH, ACK, FLUSH.
- IDLE:
  - pending-flush or flush_i set -> FLUSH (flush has priority over node_req_i).
  - else node_req_i=1 -> latch adr and far flag, read tag/data array -> LOOKUP.
- LOOKUP:
  - Hit (valid && tag match) -> ACK with the cached word; hit_count++.
  - Miss -> FETCH: mem_cyc_o=mem_stb_o=1, mem_adr_o=latched adr; miss_count++.
- FETCH:
  - Hold cyc/stb/adr until mem_ack_i=1.
  - On mem_ack_i: drop cyc/stb that edge, capture mem_dat_i, -> ACK.
  - Fill the line (valid=1, tag, data) only if far flag=0. Far misses do not allocate.
- ACK: node_ack_o=1 for exactly one cycle with node_data_o/node_adr_o = result/latched adr -> IDLE.
- Latency, req sampled at edge N:
  - Hit: node_ack_o high in the cycle after edge N+1 (2-cycle latency).
  - Miss: node_ack_o high in the cycle after the edge where mem_ack_i is sampled.
- Request ordering: core drops node_req_i at the edge that samples node_ack_o. IDLE never re-serves the same request. One request is in flight at a time.
- FLUSH: clear all valid bits in one cycle, clear pending-flush -> IDLE.
- flush_i outside IDLE sets pending-flush. The current request completes normally, including its fill, and the flush runs afterwards. Multiple pulses collapse to one.
- Reset mid-FETCH: cycle abandoned immediately (cyc low next cycle). The memory side tolerates a dropped cycle. No ack is issued.
- mem_ack_i outside FETCH is ignored.
- Counters wrap modulo 2**32 and never saturate.

Decomposition:
- Shared header raycast_defines.v: ADR_W/DATA_W defaults and FSM state encodings, reused by raycast_core benches.
- One sub-module: raycast_node_cache_mem. It holds the tag/data arrays and valid vector, with a registered read port (1-cycle), a write port, and a single-cycle clear-all.

Test Plan:
- Cold miss: req adr 0x100, mem_ack after 3 cycles with 0xDEADBEEF -> one mem cycle at 0x100; node_ack with data 0xDEADBEEF, adr 0x100; miss_count=1.
- Hit: repeat adr 0x100 -> no mem_cyc; ack exactly 2 cycles after req; hit_count=1.
- Conflict/far: req 0x140 (same index, INDEX_W=6) far=1 with data 0x11, then 0x100 -> 0x100 still hits. Then 0x140 far=0 fills; 0x100 now misses.
- Flush deferral: flush_i pulse during FETCH of 0x200 -> ack returns correct data; FLUSH follows; next 0x200 misses.
- Reset mid-FETCH: rst while mem_cyc_o=1 -> cyc low next cycle, no node_ack, counters 0, a late mem_ack ignored; 0x100 then misses.
- Back-to-back: core re-asserts req the cycle after ack with new adr 0x101 -> served without a lost or duplicated ack.
